// File: rtl/br_misc_sink.sv
// br_misc_sink: sinks unused ready/valid channels, counting events and capturing the first offending beat
module br_misc_sink #(
    parameter int NumChannels = 1,
    parameter int Width       = 1,
    parameter int CountWidth  = 8,
    parameter int ReadyValue  = 1,
    localparam int ChW        = NumChannels > 1 ? $clog2(NumChannels) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NumChannels-1:0]       in_valid,
    input  logic [NumChannels*Width-1:0] in_data,
    output logic [NumChannels-1:0]       in_ready,
    input  logic                         clear,
    output logic                         unexpected,
    output logic [CountWidth-1:0]        event_count,
    output logic [ChW-1:0]               first_channel,
    output logic [Width-1:0]             first_data
);
    localparam int NW = $clog2(NumChannels + 1);
    localparam int SW = (CountWidth > NW ? CountWidth : NW) + 1;
    if (NumChannels < 1 || Width < 1 || CountWidth < 1 || (ReadyValue != 0 && ReadyValue != 1)) begin : g_bad_param
        $error("br_misc_sink: illegal parameters");
    end
    logic [NumChannels-1:0] valid_d;
    logic [NumChannels-1:0] evt;
    logic [NW-1:0]          n;
    logic [ChW-1:0]         low_ch;
    logic [Width-1:0]       low_data;
    logic [CountWidth-1:0]  base;
    logic [SW-1:0]          sum;
    logic [CountWidth-1:0]  sat;
    assign in_ready = (ReadyValue != 0) ? '1 : '0;
    assign evt      = (ReadyValue != 0) ? in_valid : in_valid & ~valid_d;
    assign base     = clear ? '0 : event_count;
    assign sum      = SW'(base) + SW'(n);
    assign sat      = (sum > SW'({CountWidth{1'b1}})) ? '1 : sum[CountWidth-1:0];
    always_comb begin
        n        = '0;
        low_ch   = '0;
        low_data = '0;
        for (int i = NumChannels - 1; i >= 0; i--) begin
            n = n + NW'(evt[i]);
            if (evt[i]) begin
                low_ch   = ChW'(i);
                low_data = in_data[i*Width +: Width];
            end
        end
    end
    always_ff @(posedge clk) begin
        valid_d <= in_valid;
        if (rst) begin
            unexpected    <= 1'b0;
            event_count   <= '0;
            first_channel <= '0;
            first_data    <= '0;
        end else begin
            event_count <= sat;
            unexpected  <= (unexpected & ~clear) | (n != '0);
            if ((!unexpected || clear) && n != '0) begin
                first_channel <= low_ch;
                first_data    <= low_data;
            end else if (clear) begin
                first_channel <= '0;
                first_data    <= '0;
            end
        end
    end
    always @(posedge clk) begin
        if (!rst) assert (!$isunknown(in_valid)) else $error("br_misc_sink: X on in_valid");
    end
endmodule

// File: tb/tb_br_misc_sink.sv
// tb_br_misc_sink: directed checks of drain, backpressure, saturation, clear and reset behaviour
module tb_br_misc_sink;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    always #5 clk = ~clk;
    logic [3:0]  v1 = '0, v0 = '0, vs = '0;
    logic [15:0] d1 = '0, d0 = '0, ds = '0;
    logic [3:0]  r1, r0, rs;
    logic        u1, u0, us;
    logic [7:0]  c1, c0;
    logic [2:0]  cs;
    logic [1:0]  f1, f0, fs;
    logic [3:0]  fd1, fd0, fds;
    int total = 0;
    int passed = 0;
    br_misc_sink #(.NumChannels(4), .Width(4), .CountWidth(8), .ReadyValue(1)) u_drain (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(r1), .clear(clear),
        .unexpected(u1), .event_count(c1), .first_channel(f1), .first_data(fd1));
    br_misc_sink #(.NumChannels(4), .Width(4), .CountWidth(8), .ReadyValue(0)) u_bp (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(r0), .clear(clear),
        .unexpected(u0), .event_count(c0), .first_channel(f0), .first_data(fd0));
    br_misc_sink #(.NumChannels(4), .Width(4), .CountWidth(3), .ReadyValue(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(vs), .in_data(ds), .in_ready(rs), .clear(clear),
        .unexpected(us), .event_count(cs), .first_channel(fs), .first_data(fds));
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (r1 !== 4'hF) $display("FAIL reset_ready_drain got %h want f", r1); else passed++;
        total++; if (r0 !== 4'h0) $display("FAIL reset_ready_bp got %h want 0", r0); else passed++;
        total++; if (u1 !== 1'b0) $display("FAIL reset_unexpected got %b want 0", u1); else passed++;
        total++; if (c1 !== 8'd0) $display("FAIL reset_count got %0d want 0", c1); else passed++;
        total++; if (f1 !== 2'd0) $display("FAIL reset_first_channel got %0d want 0", f1); else passed++;
        total++; if (fd1 !== 4'h0) $display("FAIL reset_first_data got %h want 0", fd1); else passed++;
    endtask
    task automatic test_idle();
        for (int i = 0; i < 100; i++) step();
        total++; if (u1 !== 1'b0 || u0 !== 1'b0 || us !== 1'b0) $display("FAIL idle_unexpected got %b%b%b want 000", u1, u0, us); else passed++;
        total++; if (c1 !== 8'd0 || c0 !== 8'd0 || cs !== 3'd0) $display("FAIL idle_count got %0d/%0d/%0d want 0/0/0", c1, c0, cs); else passed++;
        total++; if (r1 !== 4'hF || r0 !== 4'h0 || rs !== 4'hF) $display("FAIL idle_ready got %h/%h/%h want f/0/f", r1, r0, rs); else passed++;
    endtask
    task automatic test_drain();
        v1 = 4'b1010;
        d1 = 16'h9050;
        step();
        v1 = 4'b0001;
        d1 = 16'h000A;
        total++; if (c1 !== 8'd2) $display("FAIL drain_count got %0d want 2", c1); else passed++;
        total++; if (u1 !== 1'b1) $display("FAIL drain_unexpected got %b want 1", u1); else passed++;
        total++; if (f1 !== 2'd1) $display("FAIL drain_first_channel got %0d want 1", f1); else passed++;
        total++; if (fd1 !== 4'h5) $display("FAIL drain_first_data got %h want 5", fd1); else passed++;
        step();
        v1 = 4'b0000;
        total++; if (c1 !== 8'd3) $display("FAIL drain_count2 got %0d want 3", c1); else passed++;
        total++; if (f1 !== 2'd1 || fd1 !== 4'h5) $display("FAIL drain_capture_kept got %0d/%h want 1/5", f1, fd1); else passed++;
    endtask
    task automatic test_backpressure();
        v0 = 4'b0001;
        d0 = 16'h000C;
        for (int i = 0; i < 10; i++) step();
        total++; if (c0 !== 8'd1) $display("FAIL bp_held_count got %0d want 1", c0); else passed++;
        total++; if (u0 !== 1'b1 || f0 !== 2'd0 || fd0 !== 4'hC) $display("FAIL bp_capture got %b/%0d/%h want 1/0/c", u0, f0, fd0); else passed++;
        v0 = 4'b0000;
        step();
        v0 = 4'b0001;
        step();
        step();
        total++; if (c0 !== 8'd2) $display("FAIL bp_edge_count got %0d want 2", c0); else passed++;
        v0 = 4'b0000;
        step();
    endtask
    task automatic test_saturation();
        vs = 4'b1111;
        ds = 16'h4321;
        step();
        total++; if (cs !== 3'd4) $display("FAIL sat_count1 got %0d want 4", cs); else passed++;
        step();
        total++; if (cs !== 3'd7) $display("FAIL sat_count2 got %0d want 7", cs); else passed++;
        step();
        total++; if (cs !== 3'd7) $display("FAIL sat_count3 got %0d want 7", cs); else passed++;
        total++; if (fs !== 2'd0 || fds !== 4'h1) $display("FAIL sat_capture got %0d/%h want 0/1", fs, fds); else passed++;
        vs = 4'b0000;
    endtask
    task automatic test_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++; if (u1 !== 1'b0 || c1 !== 8'd0 || f1 !== 2'd0 || fd1 !== 4'h0)
            $display("FAIL clear_alone got %b/%0d/%0d/%h want 0/0/0/0", u1, c1, f1, fd1); else passed++;
        v1 = 4'b0100;
        d1 = 16'h0300;
        step();
        v1 = 4'b1111;
        d1 = 16'hFFFF;
        step();
        total++; if (c1 !== 8'd5 || f1 !== 2'd2 || fd1 !== 4'h3) $display("FAIL clear_setup got %0d/%0d/%h want 5/2/3", c1, f1, fd1); else passed++;
        clear = 1'b1;
        v1 = 4'b0100;
        d1 = 16'h0700;
        step();
        clear = 1'b0;
        v1 = 4'b0000;
        total++; if (c1 !== 8'd1) $display("FAIL clear_event_count got %0d want 1", c1); else passed++;
        total++; if (u1 !== 1'b1) $display("FAIL clear_event_unexpected got %b want 1", u1); else passed++;
        total++; if (f1 !== 2'd2 || fd1 !== 4'h7) $display("FAIL clear_event_capture got %0d/%h want 2/7", f1, fd1); else passed++;
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++; if (u1 !== 1'b0 || c1 !== 8'd0 || f1 !== 2'd0 || fd1 !== 4'h0)
            $display("FAIL clear_again got %b/%0d/%0d/%h want 0/0/0/0", u1, c1, f1, fd1); else passed++;
    endtask
    task automatic test_reset_mid();
        d0 = 16'h000E;
        for (int i = 0; i < 3; i++) begin
            v0 = 4'b0001;
            step();
            v0 = 4'b0000;
            step();
        end
        total++; if (c0 !== 8'd3) $display("FAIL rstmid_setup got %0d want 3", c0); else passed++;
        v0 = 4'b0001;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        total++; if (c0 !== 8'd0) $display("FAIL rstmid_count got %0d want 0", c0); else passed++;
        total++; if (u0 !== 1'b0) $display("FAIL rstmid_unexpected got %b want 0", u0); else passed++;
        total++; if (f0 !== 2'd0 || fd0 !== 4'h0) $display("FAIL rstmid_capture got %0d/%h want 0/0", f0, fd0); else passed++;
        v0 = 4'b0000;
    endtask
    initial begin
        test_reset();
        test_idle();
        test_drain();
        test_backpressure();
        test_saturation();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
